// File: rtl/slv_txn_watchdog.sv
// Per-ID outstanding-transaction watchdog: counts requests/completions per slot,
// times outstanding slots, raises a sticky IRQ and a reset request on timeout.
// Optional statistics outputs are compiled in with `define SLV_TXN_WATCHDOG_STATS_EN.
module slv_txn_watchdog #(
    parameter int IdWidth      = 2,
    parameter int MaxTxnsPerId = 4,
    parameter int CntWidth     = 10,
    parameter int PrescalerDiv = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable_i,
    input  logic [CntWidth-1:0] budget_i,
    input  logic                req_valid_i,
    input  logic                req_ready_i,
    input  logic [IdWidth-1:0]  req_id_i,
    input  logic                rsp_valid_i,
    input  logic                rsp_ready_i,
    input  logic                rsp_last_i,
    input  logic [IdWidth-1:0]  rsp_id_i,
    output logic                irq_o,
    output logic                rst_req_o,
    input  logic                rst_stat_i,
    output logic [IdWidth-1:0]  timeout_id_o,
    output logic                busy_o,
    output logic                overflow_o,
    output logic                spurious_o
`ifdef SLV_TXN_WATCHDOG_STATS_EN
    ,
    output logic [31:0]         num_done_o,
    output logic [31:0]         num_timeouts_o
`endif
);

    localparam int NumIds  = 2 ** IdWidth;
    localparam int OcWidth = $clog2(MaxTxnsPerId + 1);
    localparam int PsWidth = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;
    localparam logic [OcWidth-1:0] MaxCnt = OcWidth'(MaxTxnsPerId);
    localparam logic [PsWidth-1:0] PsLast = PsWidth'(PrescalerDiv - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MONITOR,
        ST_TIMEOUT,
        ST_RESET_WAIT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [OcWidth-1:0]  r_cnt     [NumIds];
    logic [OcWidth-1:0]  w_cnt_nxt [NumIds];
    logic [CntWidth-1:0] r_tmr     [NumIds];
    logic [CntWidth-1:0] w_tmr_nxt [NumIds];
    logic [PsWidth-1:0]  r_ps;

    logic                r_irq;
    logic                r_rst_req;
    logic [IdWidth-1:0]  r_timeout_id;
    logic                r_overflow;
    logic                r_spurious;

    logic                w_req;
    logic                w_cpl;
    logic                w_tick;
    logic                w_release;
    logic                w_take;
    logic                w_hit;
    logic [IdWidth-1:0]  w_hit_id;
    logic                w_ovf_set;
    logic                w_spur_set;
    logic [NumIds-1:0]   w_slot_req;
    logic [NumIds-1:0]   w_slot_cpl;
    logic [NumIds-1:0]   w_slot_inc;
    logic [NumIds-1:0]   w_slot_clr;

    assign w_req     = req_valid_i && req_ready_i && enable_i;
    assign w_cpl     = rsp_valid_i && rsp_ready_i && rsp_last_i && enable_i;
    assign w_tick    = enable_i && (r_ps == PsLast);
    assign w_release = (r_state == ST_RESET_WAIT) && rst_stat_i;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_ps <= '0;
        end else if (!enable_i || (r_ps == PsLast)) begin
            r_ps <= '0;
        end else begin
            r_ps <= r_ps + PsWidth'(1);
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NumIds; i++) begin
            w_slot_req[i] = w_req && (req_id_i == IdWidth'(i));
            w_slot_cpl[i] = w_cpl && (rsp_id_i == IdWidth'(i));
            w_slot_inc[i] = w_tick && (r_cnt[i] != '0) && (r_tmr[i] != '1);
            w_slot_clr[i] = w_slot_cpl[i] || (w_slot_req[i] && (r_cnt[i] == '0));
        end
    end

    // A cleared timer does not count as incrementing, so it cannot time out that edge.
    always_comb begin
        w_ovf_set  = 1'b0;
        w_spur_set = 1'b0;
        w_hit      = 1'b0;
        w_hit_id   = '0;
        for (int unsigned i = 0; i < NumIds; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            w_tmr_nxt[i] = r_tmr[i];
            if (w_slot_clr[i]) begin
                w_tmr_nxt[i] = '0;
            end else if (w_slot_inc[i]) begin
                w_tmr_nxt[i] = r_tmr[i] + CntWidth'(1);
                if (!w_hit && (budget_i != '0) && (w_tmr_nxt[i] == budget_i)) begin
                    w_hit    = 1'b1;
                    w_hit_id = IdWidth'(i);
                end
            end
            case ({w_slot_req[i], w_slot_cpl[i]})
                2'b10: begin
                    if (r_cnt[i] == MaxCnt) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + OcWidth'(1);
                    end
                end
                2'b01: begin
                    if (r_cnt[i] == '0) begin
                        w_spur_set = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] - OcWidth'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int unsigned i = 0; i < NumIds; i++) begin
                r_cnt[i] <= '0;
                r_tmr[i] <= '0;
            end
        end else if (w_release) begin
            for (int unsigned i = 0; i < NumIds; i++) begin
                r_cnt[i] <= '0;
                r_tmr[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NumIds; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
                r_tmr[i] <= w_tmr_nxt[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Timeouts are only accepted in MONITOR; later ones are dropped until release.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable_i) begin
                    w_state_nxt = ST_MONITOR;
                end
            end
            ST_MONITOR: begin
                if (!enable_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_hit) begin
                    w_state_nxt = ST_TIMEOUT;
                    w_take      = 1'b1;
                end
            end
            ST_TIMEOUT: begin
                w_state_nxt = ST_RESET_WAIT;
            end
            ST_RESET_WAIT: begin
                if (rst_stat_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_irq        <= 1'b0;
            r_rst_req    <= 1'b0;
            r_timeout_id <= '0;
            r_overflow   <= 1'b0;
            r_spurious   <= 1'b0;
        end else begin
            if (w_take) begin
                r_irq        <= 1'b1;
                r_timeout_id <= w_hit_id;
            end
            if (r_state == ST_TIMEOUT) begin
                r_rst_req <= 1'b1;
            end
            if (w_release) begin
                r_irq     <= 1'b0;
                r_rst_req <= 1'b0;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
            if (w_spur_set) begin
                r_spurious <= 1'b1;
            end
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int unsigned i = 0; i < NumIds; i++) begin
            busy_o = busy_o | (r_cnt[i] != '0);
        end
    end

    assign irq_o        = r_irq;
    assign rst_req_o    = r_rst_req;
    assign timeout_id_o = r_timeout_id;
    assign overflow_o   = r_overflow;
    assign spurious_o   = r_spurious;

`ifdef SLV_TXN_WATCHDOG_STATS_EN
    logic [31:0] r_num_done;
    logic [31:0] r_num_timeouts;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_num_done     <= '0;
            r_num_timeouts <= '0;
        end else begin
            if (w_cpl && (r_num_done != '1)) begin
                r_num_done <= r_num_done + 32'd1;
            end
            if (w_take && (r_num_timeouts != '1)) begin
                r_num_timeouts <= r_num_timeouts + 32'd1;
            end
        end
    end

    assign num_done_o     = r_num_done;
    assign num_timeouts_o = r_num_timeouts;
`endif

endmodule

// File: tb/tb_slv_txn_watchdog.sv
// Scoreboard bench for slv_txn_watchdog: stimulus queues expected snapshots and
// IRQ events, a negedge monitor pops and compares them.
module tb_slv_txn_watchdog;

    typedef struct {
        int         cyc;
        logic       irq;
        logic       rreq;
        logic       busy;
        logic       ovf;
        logic       spur;
        logic       id_care;
        logic [1:0] id;
        int         ntmo;
    } snap_t;

    typedef struct {
        int         cyc;
        logic [1:0] id;
    } evt_t;

    logic       clk;
    logic       rst_n;
    logic       enable_a;
    logic       enable_b;
    logic [9:0] budget_a;
    logic [9:0] budget_b;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_id;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_last;
    logic [1:0] rsp_id;
    logic       rst_stat;

    logic       irq_a, rreq_a, busy_a, ovf_a, spur_a;
    logic [1:0] tid_a;
    logic       irq_b, rreq_b, busy_b, ovf_b, spur_b;
    logic [1:0] tid_b;
`ifdef SLV_TXN_WATCHDOG_STATS_EN
    logic [31:0] ndone_a, ntmo_a, ndone_b, ntmo_b;
`endif

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    logic  done = 1'b0;
    snap_t qs[$];
    evt_t  qa[$];
    evt_t  qb[$];

    slv_txn_watchdog dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable_a),
        .budget_i     (budget_a),
        .req_valid_i  (req_valid),
        .req_ready_i  (req_ready),
        .req_id_i     (req_id),
        .rsp_valid_i  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_last_i   (rsp_last),
        .rsp_id_i     (rsp_id),
        .irq_o        (irq_a),
        .rst_req_o    (rreq_a),
        .rst_stat_i   (rst_stat),
        .timeout_id_o (tid_a),
        .busy_o       (busy_a),
        .overflow_o   (ovf_a),
        .spurious_o   (spur_a)
`ifdef SLV_TXN_WATCHDOG_STATS_EN
        ,
        .num_done_o     (ndone_a),
        .num_timeouts_o (ntmo_a)
`endif
    );

    slv_txn_watchdog #(
        .PrescalerDiv (4)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable_b),
        .budget_i     (budget_b),
        .req_valid_i  (req_valid),
        .req_ready_i  (req_ready),
        .req_id_i     (req_id),
        .rsp_valid_i  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_last_i   (rsp_last),
        .rsp_id_i     (rsp_id),
        .irq_o        (irq_b),
        .rst_req_o    (rreq_b),
        .rst_stat_i   (rst_stat),
        .timeout_id_o (tid_b),
        .busy_o       (busy_b),
        .overflow_o   (ovf_b),
        .spurious_o   (spur_b)
`ifdef SLV_TXN_WATCHDOG_STATS_EN
        ,
        .num_done_o     (ndone_b),
        .num_timeouts_o (ntmo_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic drive_step(input logic rq, input logic [1:0] rid,
                              input logic rs, input logic ls, input logic [1:0] sid);
        req_valid = rq;
        req_ready = rq;
        req_id    = rid;
        rsp_valid = rs;
        rsp_ready = rs;
        rsp_last  = ls;
        rsp_id    = sid;
        step();
        req_valid = 1'b0;
        req_ready = 1'b0;
        req_id    = 2'd0;
        rsp_valid = 1'b0;
        rsp_ready = 1'b0;
        rsp_last  = 1'b0;
        rsp_id    = 2'd0;
    endtask

    task automatic exp_snap(input int c, input logic irq, input logic rreq, input logic busy,
                            input logic ovf, input logic spur, input logic care,
                            input logic [1:0] id, input int ntmo);
        snap_t s;
        s.cyc = c; s.irq = irq; s.rreq = rreq; s.busy = busy; s.ovf = ovf;
        s.spur = spur; s.id_care = care; s.id = id; s.ntmo = ntmo;
        qs.push_back(s);
    endtask

    task automatic exp_irq(input logic which_b, input int c, input logic [1:0] id);
        evt_t e;
        e.cyc = c;
        e.id  = id;
        if (which_b) qb.push_back(e);
        else qa.push_back(e);
    endtask

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, c, act, exp);
        end
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        logic  irq_a_q;
        logic  irq_b_q;
        snap_t s;
        evt_t  e;
        irq_a_q = 1'b0;
        irq_b_q = 1'b0;
        forever begin
            @(negedge clk);
            if (irq_a && !irq_a_q) begin
                if (qa.size() == 0) begin
                    chk("irq_a_unexpected", cyc, 32'd1, 32'd0);
                end else begin
                    e = qa.pop_front();
                    chk("irq_a_cycle", cyc, cyc, e.cyc);
                    chk("irq_a_id", cyc, 32'(tid_a), 32'(e.id));
                end
            end
            if (irq_b && !irq_b_q) begin
                if (qb.size() == 0) begin
                    chk("irq_b_unexpected", cyc, 32'd1, 32'd0);
                end else begin
                    e = qb.pop_front();
                    chk("irq_b_cycle", cyc, cyc, e.cyc);
                    chk("irq_b_id", cyc, 32'(tid_b), 32'(e.id));
                end
            end
            irq_a_q = irq_a;
            irq_b_q = irq_b;
            while (qs.size() > 0 && qs[0].cyc <= cyc) begin
                s = qs.pop_front();
                if (s.cyc != cyc) begin
                    chk("snap_missed", cyc, cyc, s.cyc);
                end else begin
                    chk("irq", cyc, 32'(irq_a), 32'(s.irq));
                    chk("rst_req", cyc, 32'(rreq_a), 32'(s.rreq));
                    chk("busy", cyc, 32'(busy_a), 32'(s.busy));
                    chk("overflow", cyc, 32'(ovf_a), 32'(s.ovf));
                    chk("spurious", cyc, 32'(spur_a), 32'(s.spur));
                    if (s.id_care) chk("timeout_id", cyc, 32'(tid_a), 32'(s.id));
`ifdef SLV_TXN_WATCHDOG_STATS_EN
                    if (s.ntmo >= 0) chk("num_timeouts", cyc, ntmo_a, 32'(s.ntmo));
`endif
                end
            end
            if (done) begin
                chk("irq_a_pending", cyc, 32'(qa.size()), 32'd0);
                chk("irq_b_pending", cyc, 32'(qb.size()), 32'd0);
                chk("snap_pending", cyc, 32'(qs.size()), 32'd0);
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    initial begin : guard
        #200000;
        $display("FAIL watchdog_timeout cyc=%0d actual=running expected=finished", cyc);
        $fatal(1);
    end

    initial begin : stimulus
        int h;
        rst_n     = 1'b1;
        enable_a  = 1'b0;
        enable_b  = 1'b0;
        budget_a  = 10'd8;
        budget_b  = 10'd3;
        req_valid = 1'b0;
        req_ready = 1'b0;
        req_id    = 2'd0;
        rsp_valid = 1'b0;
        rsp_ready = 1'b0;
        rsp_last  = 1'b0;
        rsp_id    = 2'd0;
        rst_stat  = 1'b0;

        // Reset state
        step();
        step();
        exp_snap(cyc, 0, 0, 0, 0, 0, 1, 2'd0, 0);
        rst_n    = 1'b0;
        enable_a = 1'b1;
        step();
        step();

        // Timeout on ID 2; a later slot-0 expiry during RESET_WAIT is ignored
        drive_step(1, 2'd2, 0, 0, 2'd0);
        h = cyc;
        exp_irq(0, h + 8, 2'd2);
        exp_snap(h + 7,  0, 0, 1, 0, 0, 0, 2'd0, -1);
        exp_snap(h + 8,  1, 0, 1, 0, 0, 1, 2'd2, 1);
        exp_snap(h + 9,  1, 1, 1, 0, 0, 1, 2'd2, -1);
        exp_snap(h + 11, 1, 1, 1, 0, 0, 1, 2'd2, 1);
        exp_snap(h + 12, 0, 0, 0, 0, 0, 1, 2'd2, -1);
        step_to(h + 2);
        drive_step(1, 2'd0, 0, 0, 2'd0);
        step_to(h + 11);
        rst_stat = 1'b1;
        step();
        rst_stat = 1'b0;
        step();

        // Completion after 5 cycles on ID 1 (non-last beat in between must not count)
        drive_step(1, 2'd1, 0, 0, 2'd0);
        h = cyc;
        exp_snap(h + 4,  0, 0, 1, 0, 0, 0, 2'd0, -1);
        exp_snap(h + 5,  0, 0, 0, 0, 0, 0, 2'd0, -1);
        exp_snap(h + 12, 0, 0, 0, 0, 0, 0, 2'd0, -1);
        step_to(h + 1);
        drive_step(0, 2'd0, 1, 0, 2'd1);
        step_to(h + 4);
        drive_step(0, 2'd0, 1, 1, 2'd1);
        step_to(h + 12);
        step();

        // Overflow on ID 3, drain four completions, then spurious on ID 0
        drive_step(1, 2'd3, 0, 0, 2'd0);
        h = cyc;
        exp_snap(h + 3, 0, 0, 1, 0, 0, 0, 2'd0, -1);
        exp_snap(h + 4, 0, 0, 1, 1, 0, 0, 2'd0, -1);
        exp_snap(h + 7, 0, 0, 1, 1, 0, 0, 2'd0, -1);
        exp_snap(h + 8, 0, 0, 0, 1, 0, 0, 2'd0, -1);
        exp_snap(h + 9, 0, 0, 0, 1, 1, 0, 2'd0, -1);
        for (int i = 0; i < 4; i++) drive_step(1, 2'd3, 0, 0, 2'd0);
        for (int i = 0; i < 4; i++) drive_step(0, 2'd0, 1, 1, 2'd3);
        drive_step(0, 2'd0, 1, 1, 2'd0);
        step();

        // IDs 1 and 3 expire on the same edge: lowest index reported
        drive_step(1, 2'd3, 0, 0, 2'd0);
        h = cyc;
        drive_step(1, 2'd3, 0, 0, 2'd0);
        drive_step(1, 2'd1, 1, 1, 2'd3);
        exp_irq(0, h + 10, 2'd1);
        exp_snap(h + 10, 1, 0, 1, 1, 1, 1, 2'd1, 2);
        exp_snap(h + 11, 1, 1, 1, 1, 1, 1, 2'd1, -1);
        exp_snap(h + 12, 0, 0, 0, 1, 1, 1, 2'd1, 2);
        step_to(h + 11);
        rst_stat = 1'b1;
        step();
        rst_stat = 1'b0;
        step();

        // Asynchronous reset mid-transaction
        drive_step(1, 2'd2, 0, 0, 2'd0);
        h = cyc;
        exp_snap(h + 1, 0, 0, 1, 1, 1, 1, 2'd1, -1);
        exp_snap(h + 2, 0, 0, 0, 0, 0, 1, 2'd0, 0);
        step_to(h + 2);
        #1;
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;

        // Prescaled instance: PrescalerDiv 4, budget 3
        enable_a = 1'b0;
        enable_b = 1'b1;
        step();
        drive_step(1, 2'd0, 0, 0, 2'd0);
        h = cyc;
        exp_irq(1, h + 10, 2'd0);
        step_to(h + 12);

        done = 1'b1;
    end

endmodule

// File: doc/slv_txn_watchdog.md
SLV_TXN_WATCHDOG -- requirements
Module: slv_txn_watchdog

Interface
REQ-001 SHALL have parameter IdWidth, default 2, transaction ID width; tracked slots NumIds = 2**IdWidth, slot index = ID.
REQ-002 SHALL have parameter MaxTxnsPerId, default 4, outstanding transactions per ID, >= 1.
REQ-003 SHALL have parameter CntWidth, default 10, timer and budget width.
REQ-004 SHALL have parameter PrescalerDiv, default 1, clock cycles per timer tick, >= 1.
REQ-005 SHALL have port clk, input, 1, clock; all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous, active-high.
REQ-007 SHALL have ports enable_i (input, 1, monitoring enable) and budget_i (input, CntWidth, timeout budget in ticks; 0 = timeout disabled).
REQ-008 SHALL have ports req_valid_i, req_ready_i (input, 1 each) and req_id_i (input, IdWidth): request handshake observed on the bus.
REQ-009 SHALL have ports rsp_valid_i, rsp_ready_i, rsp_last_i (input, 1 each) and rsp_id_i (input, IdWidth): response handshake observed on the bus.
REQ-010 SHALL have ports irq_o (output, 1, sticky timeout interrupt), rst_req_o (output, 1, reset request), rst_stat_i (input, 1, reset-done acknowledge).
REQ-011 SHALL have ports timeout_id_o (output, IdWidth, first offending ID), busy_o (output, 1, any slot outstanding), overflow_o and spurious_o (output, 1 each, sticky error flags).

Function
REQ-012 SHALL count a request when req_valid_i && req_ready_i && enable_i; a response completion when rsp_valid_i && rsp_ready_i && rsp_last_i && enable_i.
REQ-013 SHALL keep per-slot outstanding count 0..MaxTxnsPerId and per-slot timer of CntWidth bits.
REQ-014 SHALL increment slot count on request, decrement on completion; both same slot same cycle: count unchanged, timer cleared.
REQ-015 SHALL clear slot timer on every completion and on a request taking count from 0 to 1.
REQ-016 SHALL generate a tick every PrescalerDiv cycles from a free-running prescaler counter, which wraps to 0 and is held at 0 while enable_i is low.
REQ-017 SHALL increment slot timer on each tick while count > 0, saturating at all-ones.
REQ-018 SHALL detect timeout on the edge where a timer increments to equal budget_i with budget_i != 0; lowest-index slot wins when several coincide.
REQ-019 SHALL run global FSM IDLE -> MONITOR (enable_i high) -> TIMEOUT (timeout detected) -> RESET_WAIT -> IDLE; MONITOR -> IDLE when enable_i low.
REQ-020 SHALL, entering TIMEOUT, register irq_o = 1 and latch timeout_id_o on the detecting edge; TIMEOUT moves to RESET_WAIT next cycle.
REQ-021 SHALL hold rst_req_o = 1 in RESET_WAIT until rst_stat_i = 1, then clear all counts, timers, irq_o, rst_req_o and go IDLE next edge.
REQ-022 SHALL, on request to a slot at MaxTxnsPerId, saturate count and set overflow_o sticky.
REQ-023 SHALL, on completion to a slot at count 0, leave count at 0 and set spurious_o sticky.
REQ-024 SHALL ignore further timeouts while in TIMEOUT or RESET_WAIT; timeout_id_o holds the first.
REQ-025 SHALL drive busy_o combinationally as OR of (count != 0) over all slots.

Reset
REQ-026 SHALL, while rst_n = 1, asynchronously force FSM IDLE, all counts, timers, prescaler 0, irq_o, rst_req_o, overflow_o, spurious_o, timeout_id_o to 0; mid-transaction state is discarded.

Configuration
REQ-027 SHALL, with SLV_TXN_WATCHDOG_STATS_EN defined, add outputs num_done_o and num_timeouts_o (32 bits each, saturating, cleared by reset only) counting completions and timeout events.
REQ-028 SHALL, without SLV_TXN_WATCHDOG_STATS_EN, omit those ports and counters entirely.

Verification
REQ-029 SHALL cover: defaults, budget 8, request ID 2, no response -> irq_o = 1 and timeout_id_o = 2 exactly 8 cycles after handshake, rst_req_o = 1 one cycle later.
REQ-030 SHALL cover: budget 8, request ID 1, last response after 5 cycles -> no irq_o, busy_o = 0 one cycle after completion.
REQ-031 SHALL cover: PrescalerDiv 4, budget 3, request ID 0 -> irq_o within 9..12 cycles, not before.
REQ-032 SHALL cover: 5 requests on ID 3 without responses (MaxTxnsPerId 4) -> overflow_o = 1, count 4; completion with count 0 on ID 0 -> spurious_o = 1.
REQ-033 SHALL cover: in RESET_WAIT pulse rst_stat_i -> irq_o, rst_req_o = 0 and busy_o = 0 next cycle; rst_n = 1 mid-transaction -> all outputs 0 immediately.
REQ-034 SHALL cover: timeouts on IDs 1 and 3 same edge -> timeout_id_o = 1; with STATS_EN, num_timeouts_o = 1.
